// File: rtl/and_or_pkg.sv
// ============================================================================
// Module : and_or_pkg
// Brief  : Mode encodings shared by the pipelined AND-OR block.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package and_or_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_AO   = 2'b00;  // (a & b) | c
    localparam mode_t MODE_OA   = 2'b01;  // (a | b) & c
    localparam mode_t MODE_AND3 = 2'b10;  // a & b & c
    localparam mode_t MODE_OR3  = 2'b11;  // a | b | c

endpackage : and_or_pkg

`default_nettype wire

// File: rtl/and_or_func.sv
// ============================================================================
// Module : and_or_func
// Brief  : Combinational per-bit two-level logic function selected by mode.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module and_or_func
    import and_or_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  mode_t              mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   c,
    output logic [WIDTH-1:0]   y
);

    always_comb begin
        y = '0;
        case (mode)
            MODE_AO:   y = (a & b) | c;
            MODE_OA:   y = (a | b) & c;
            MODE_AND3: y = a & b & c;
            MODE_OR3:  y = a | b | c;
            default:   y = '0;
        endcase
    end

endmodule : and_or_func

`default_nettype wire

// File: rtl/and_or_pipe.sv
// ============================================================================
// Module : and_or_pipe
// Brief  : Two-stage valid/ready pipeline around and_or_func with any/all
//          reduction flags and a saturating delivered-result counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module and_or_pipe
    import and_or_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   c,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   y,
    output logic               y_any,
    output logic               y_all,
    input  logic               clear,
    output logic [CNT_W-1:0]   result_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic               s1_valid;
    mode_t              s1_mode;
    logic [WIDTH-1:0]   s1_a;
    logic [WIDTH-1:0]   s1_b;
    logic [WIDTH-1:0]   s1_c;

    logic               s2_valid;
    logic [WIDTH-1:0]   s2_y;
    logic               s2_any;
    logic               s2_all;

    logic               s1_adv;
    logic               s2_adv;
    logic [WIDTH-1:0]   func_y;
    logic               out_xfer;

    // Ready depends only on pipeline state and out_ready, never on in_valid.
    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;
    assign out_xfer = s2_valid && out_ready;

    and_or_func #(
        .WIDTH (WIDTH)
    ) u_func (
        .mode  (s1_mode),
        .a     (s1_a),
        .b     (s1_b),
        .c     (s1_c),
        .y     (func_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mode  <= MODE_AO;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_c     <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mode <= mode_t'(mode);
                s1_a    <= a;
                s1_b    <= b;
                s1_c    <= c;
            end
        end
    end

    // Only real beats reach stage 2, so bubbles leave y untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_y     <= '0;
            s2_any   <= 1'b0;
            s2_all   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_y   <= func_y;
                s2_any <= |func_y;
                s2_all <= &func_y;
            end
        end
    end

    // Clear wins over a same-cycle transfer; that transfer is dropped from the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_cnt <= '0;
        end else if (clear) begin
            result_cnt <= '0;
        end else if (out_xfer && (result_cnt != CNT_MAX)) begin
            result_cnt <= result_cnt + 1'b1;
        end
    end

    assign out_valid = s2_valid;
    assign y         = s2_y;
    assign y_any     = s2_any;
    assign y_all     = s2_all;

endmodule : and_or_pipe

`default_nettype wire

// File: tb/tb_and_or_pipe.sv
// ============================================================================
// Module : tb_and_or_pipe
// Brief  : Self-checking bench for and_or_pipe (default and 2-bit counter).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_and_or_pipe;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a, b, c;
    logic             out_ready;
    logic             clear;

    logic             in_ready, out_valid, y_any, y_all;
    logic [WIDTH-1:0] y;
    logic [15:0]      result_cnt;

    logic             in_ready_s, out_valid_s, y_any_s, y_all_s;
    logic [WIDTH-1:0] y_s;
    logic [1:0]       result_cnt_s;

    int n_cmp = 0;
    int n_err = 0;

    logic [9:0] sb[$];   // {any, all, y}

    always #5 clk = ~clk;

    and_or_pipe #(.WIDTH(WIDTH), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .a(a), .b(b), .c(c), .out_valid(out_valid),
        .out_ready(out_ready), .y(y), .y_any(y_any), .y_all(y_all),
        .clear(clear), .result_cnt(result_cnt)
    );

    and_or_pipe #(.WIDTH(WIDTH), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .mode(mode), .a(a), .b(b), .c(c), .out_valid(out_valid_s),
        .out_ready(out_ready), .y(y_s), .y_any(y_any_s), .y_all(y_all_s),
        .clear(clear), .result_cnt(result_cnt_s)
    );

    function automatic logic [9:0] ref_f(input logic [1:0] m, input logic [7:0] xa,
                                         input logic [7:0] xb, input logic [7:0] xc);
        logic [7:0] r;
        logic any_v, all_v;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            case (m)
                2'd0: r[i] = (xa[i] && xb[i]) || xc[i];
                2'd1: r[i] = (xa[i] || xb[i]) && xc[i];
                2'd2: r[i] = xa[i] && xb[i] && xc[i];
                default: r[i] = xa[i] || xb[i] || xc[i];
            endcase
        end
        any_v = 1'b0;
        all_v = 1'b1;
        for (int i = 0; i < 8; i++) begin
            any_v = any_v || r[i];
            all_v = all_v && r[i];
        end
        return {any_v, all_v, r};
    endfunction

    task automatic idle_inputs();
        in_valid  = 1'b0;
        mode      = 2'd0;
        a = '0; b = '0; c = '0;
        out_ready = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || y !== 8'h00 || result_cnt !== 16'd0 || in_ready !== 1'b1
            || y_any !== 1'b0 || y_all !== 1'b0) begin
            n_err++;
            $display("FAIL reset_init: ov=%b y=%h cnt=%0d ir=%b any=%b all=%b, want 0 0 0 1 0 0",
                     out_valid, y, result_cnt, in_ready, y_any, y_all);
        end
        @(negedge clk) rst_n = 1'b1;
        // Push two beats in, with output stalled, then reset mid-stream.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            in_valid = 1'b1; mode = 2'd3; a = 8'h5A; b = 8'h00; c = 8'h00;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || y !== 8'h00 || result_cnt !== 16'd0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid: ov=%b y=%h cnt=%0d ir=%b, want 0 00 0 1",
                     out_valid, y, result_cnt, in_ready);
        end
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL reset_discard: out_valid=%b at cycle %0d, want 0", out_valid, k);
            end
        end
    endtask

    task automatic test_modes();
        logic [7:0] exp_y[4];
        logic       exp_any[4];
        int         got;
        exp_y[0] = 8'hCA; exp_y[1] = 8'h08; exp_y[2] = 8'h00; exp_y[3] = 8'hFE;
        exp_any[0] = 1'b1; exp_any[1] = 1'b1; exp_any[2] = 1'b0; exp_any[3] = 1'b1;
        got = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k < 4) begin
                in_valid = 1'b1; mode = k[1:0]; a = 8'hF0; b = 8'hCC; c = 8'h0A;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            n_cmp++;
            if (out_valid !== (k >= 2 && k <= 5)) begin
                n_err++;
                $display("FAIL modes_latency: cycle %0d out_valid=%b, want %b",
                         k, out_valid, (k >= 2 && k <= 5));
            end
            if (out_valid === 1'b1 && got < 4) begin
                n_cmp++;
                if (y !== exp_y[got] || y_any !== exp_any[got] || y_all !== 1'b0) begin
                    n_err++;
                    $display("FAIL modes_y%0d: y=%h any=%b all=%b, want %h %b 0",
                             got, y, y_any, y_all, exp_y[got], exp_any[got]);
                end
                got++;
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] va[3];
        logic [9:0] e;
        int acc, outs, t;
        va[0] = 8'h11; va[1] = 8'h22; va[2] = 8'h44;
        acc = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1; mode = 2'd3; a = va[acc]; b = 8'h00; c = 8'h00;
            #1;
            if (in_ready) begin
                sb.push_back(ref_f(2'd3, va[acc], 8'h00, 8'h00));
                acc++;
            end
        end
        n_cmp++;
        if (acc !== 2 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL stall_accept: accepted=%0d in_ready=%b, want 2 0", acc, in_ready);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || y !== 8'h11 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold: ov=%b y=%h ir=%b, want 1 11 0", out_valid, y, in_ready);
            end
        end
        outs = 0;
        t = 0;
        while (outs < 3 && t < 20) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (acc < 3) begin
                in_valid = 1'b1; a = va[acc];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && in_ready) begin
                sb.push_back(ref_f(2'd3, va[acc], 8'h00, 8'h00));
                acc++;
            end
            if (out_valid && out_ready) begin
                e = sb.pop_front();
                n_cmp++;
                if ({y_any, y_all, y} !== e) begin
                    n_err++;
                    $display("FAIL stall_order%0d: got %h, want %h", outs, {y_any, y_all, y}, e);
                end
                outs++;
            end
            t++;
        end
        n_cmp++;
        if (outs !== 3) begin
            n_err++;
            $display("FAIL stall_drain: delivered %0d, want 3", outs);
        end
        in_valid = 1'b0;
        sb.delete();
    endtask

    task automatic send_one(input logic [1:0] m, input logic [7:0] xa, input logic [7:0] xb,
                            input logic [7:0] xc, output bit ok);
        int t;
        @(negedge clk);
        in_valid = 1'b1; mode = m; a = xa; b = xb; c = xc;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        t = 0;
        #1;
        while (!out_valid && t < 10) begin
            @(negedge clk); #1;
            t++;
        end
        ok = out_valid;
    endtask

    task automatic test_reduction();
        bit ok;
        send_one(2'd2, 8'hFF, 8'hFF, 8'hFF, ok);
        n_cmp++;
        if (!ok || y !== 8'hFF || y_any !== 1'b1 || y_all !== 1'b1) begin
            n_err++;
            $display("FAIL reduction: ok=%0d y=%h any=%b all=%b, want 1 ff 1 1", ok, y, y_any, y_all);
        end
        @(negedge clk) out_ready = 1'b1;
        @(negedge clk) out_ready = 1'b0;
    endtask

    task automatic test_counter();
        bit ok;
        logic [1:0] exp_s[5];
        exp_s[0] = 2'd1; exp_s[1] = 2'd2; exp_s[2] = 2'd3; exp_s[3] = 2'd3; exp_s[4] = 2'd3;
        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
        #1;
        n_cmp++;
        if (result_cnt !== 16'd0 || result_cnt_s !== 2'd0) begin
            n_err++;
            $display("FAIL cnt_clear: cnt=%0d small=%0d, want 0 0", result_cnt, result_cnt_s);
        end
        for (int k = 0; k < 5; k++) begin
            send_one(2'(k), 8'h0F, 8'h3C, 8'h81, ok);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            #1;
            n_cmp++;
            if (!ok || result_cnt !== 16'(k + 1) || result_cnt_s !== exp_s[k]) begin
                n_err++;
                $display("FAIL cnt_step%0d: cnt=%0d small=%0d, want %0d %0d",
                         k, result_cnt, result_cnt_s, k + 1, exp_s[k]);
            end
        end
        send_one(2'd0, 8'h01, 8'h01, 8'h00, ok);
        out_ready = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        clear = 1'b0;
        #1;
        n_cmp++;
        if (!ok || result_cnt !== 16'd0 || result_cnt_s !== 2'd0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL cnt_clear_xfer: cnt=%0d small=%0d ov=%b, want 0 0 0",
                     result_cnt, result_cnt_s, out_valid);
        end
    endtask

    task automatic test_random();
        int n_in, n_out, t;
        bit took;
        logic [9:0] e;
        n_in = 0; n_out = 0; took = 0;
        sb.delete();
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (took) in_valid = 1'b0;
            if (!in_valid && k < 500 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                mode = 2'($urandom_range(0, 3));
                a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
            end
            out_ready = (k >= 500) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            n_cmp++;
            if ($isunknown({in_ready, out_valid, y, y_any, y_all, result_cnt,
                            in_ready_s, out_valid_s, y_s, y_any_s, y_all_s, result_cnt_s})) begin
                n_err++;
                $display("FAIL rand_x: cycle %0d y=%h ov=%b ir=%b cnt=%h, want no X",
                         k, y, out_valid, in_ready, result_cnt);
            end
            took = in_valid && in_ready;
            if (took) begin
                sb.push_back(ref_f(mode, a, b, c));
                n_in++;
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL rand_extra: output %h with empty scoreboard", y);
                end else begin
                    e = sb.pop_front();
                    if ({y_any, y_all, y} !== e || {y_any_s, y_all_s, y_s} !== e) begin
                        n_err++;
                        $display("FAIL rand_data%0d: got %h / %h, want %h",
                                 n_out, {y_any, y_all, y}, {y_any_s, y_all_s, y_s}, e);
                    end
                end
                n_out++;
            end
        end
        t = 0;
        while (out_valid && t < 10) begin
            @(negedge clk); #1;
            t++;
        end
        n_cmp++;
        if (n_in !== n_out || sb.size() != 0) begin
            n_err++;
            $display("FAIL rand_count: in=%0d out=%0d left=%0d, want equal and 0",
                     n_in, n_out, sb.size());
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_modes();
        test_stall();
        test_reduction();
        test_counter();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_and_or_pipe

`default_nettype wire
